// File: rtl/mac_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// mac_layer_sequencer_if
// Bundles every non-clock/reset signal of the MAC layer sequencer.
//   Layer control : start, cfg_num_neurons, cfg_num_chunks, cfg_op_mode,
//                   busy, layer_done, err_timeout
//   DMA stream    : dma_valid (in), dma_ready (out)
//   Datapath      : mac_en, mac_clr, mac_read_en, mac_op_mode (out),
//                   mac_done, mac_result (in), bias_idx (out)
//   Result stream : res_valid, res_data, res_index (out), res_ready (in)
// Modport master is the sequencer side; modport slave is the environment.
// ---------------------------------------------------------------------------
interface mac_layer_sequencer_if #(
    parameter int NEURON_W = 10,
    parameter int CHUNK_W  = 8,
    parameter int DATA_W   = 16
);
    logic                start;
    logic [NEURON_W-1:0] cfg_num_neurons;
    logic [CHUNK_W-1:0]  cfg_num_chunks;
    logic                cfg_op_mode;
    logic                busy;
    logic                layer_done;
    logic                err_timeout;
    logic                dma_valid;
    logic                dma_ready;
    logic [NEURON_W-1:0] bias_idx;
    logic                mac_en;
    logic                mac_clr;
    logic                mac_read_en;
    logic                mac_op_mode;
    logic                mac_done;
    logic [DATA_W-1:0]   mac_result;
    logic                res_valid;
    logic                res_ready;
    logic [DATA_W-1:0]   res_data;
    logic [NEURON_W-1:0] res_index;

    modport master (
        input  start, cfg_num_neurons, cfg_num_chunks, cfg_op_mode,
        input  dma_valid, mac_done, mac_result, res_ready,
        output busy, layer_done, err_timeout, dma_ready, bias_idx,
        output mac_en, mac_clr, mac_read_en, mac_op_mode,
        output res_valid, res_data, res_index
    );

    modport slave (
        output start, cfg_num_neurons, cfg_num_chunks, cfg_op_mode,
        output dma_valid, mac_done, mac_result, res_ready,
        input  busy, layer_done, err_timeout, dma_ready, bias_idx,
        input  mac_en, mac_clr, mac_read_en, mac_op_mode,
        input  res_valid, res_data, res_index
    );
endinterface

// File: rtl/mac_layer_sequencer.sv
// ---------------------------------------------------------------------------
// mac_layer_sequencer
// Control FSM that walks one MAC datapath through a full layer: for each
// output neuron it clears the accumulator, streams cfg_num_chunks DMA beats,
// requests readout, waits for done (bounded by TIMEOUT cycles) and emits the
// result on a valid/ready stream tagged with the neuron index.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mac_layer_sequencer_if.master (layer control, DMA, datapath,
//           result stream)
// ---------------------------------------------------------------------------
module mac_layer_sequencer #(
    parameter int NEURON_W = 10,
    parameter int CHUNK_W  = 8,
    parameter int DATA_W   = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mac_layer_sequencer_if.master bus
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_READ,
        S_WAIT_DONE,
        S_EMIT
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [NEURON_W-1:0] r_num_neurons;
    logic [CHUNK_W-1:0]  r_num_chunks;
    logic                r_op_mode;
    logic [NEURON_W-1:0] r_neuron_cnt;
    logic [CHUNK_W-1:0]  r_chunk_cnt;
    logic [TO_W-1:0]     r_tcnt;
    logic                r_err_timeout;
    logic                r_layer_done;
    logic [DATA_W-1:0]   r_res_data;
    logic [NEURON_W-1:0] r_res_index;

    logic                w_cfg_ok;
    logic                w_last_beat;
    logic                w_last_neuron;
    logic                w_timeout_hit;
    logic                w_dma_ready;
    logic                w_mac_en;
    logic                w_mac_clr;
    logic                w_mac_read_en;
    logic                w_res_valid;

    assign w_cfg_ok      = (|bus.cfg_num_neurons) && (|bus.cfg_num_chunks);
    assign w_last_beat   = (r_chunk_cnt == r_num_chunks - CHUNK_W'(1));
    assign w_last_neuron = (r_neuron_cnt == r_num_neurons - NEURON_W'(1));
    // Last WAIT_DONE cycle: without done here the wait has lasted TIMEOUT cycles.
    assign w_timeout_hit = (r_tcnt == TO_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and Moore/Mealy control outputs
    always_comb begin
        w_next        = r_state;
        w_dma_ready   = 1'b0;
        w_mac_en      = 1'b0;
        w_mac_clr     = 1'b0;
        w_mac_read_en = 1'b0;
        w_res_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && w_cfg_ok) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_mac_clr = 1'b1;
                w_next    = S_FEED;
            end
            S_FEED: begin
                w_dma_ready = 1'b1;
                // The beat is consumed in the same cycle it is offered.
                w_mac_en    = bus.dma_valid;
                if (bus.dma_valid && w_last_beat) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                w_mac_read_en = 1'b1;
                w_next        = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // done takes priority over a coincident timeout
                if (bus.mac_done) begin
                    w_next = S_EMIT;
                end else if (w_timeout_hit) begin
                    w_next = S_IDLE;
                end
            end
            S_EMIT: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_next = w_last_neuron ? S_IDLE : S_CLEAR;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Configuration, counters, result capture and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_neurons <= '0;
            r_num_chunks  <= '0;
            r_op_mode     <= 1'b0;
            r_neuron_cnt  <= '0;
            r_chunk_cnt   <= '0;
            r_tcnt        <= '0;
            r_err_timeout <= 1'b0;
            r_layer_done  <= 1'b0;
            r_res_data    <= '0;
            r_res_index   <= '0;
        end else begin
            r_layer_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_cfg_ok) begin
                            r_num_neurons <= bus.cfg_num_neurons;
                            r_num_chunks  <= bus.cfg_num_chunks;
                            r_op_mode     <= bus.cfg_op_mode;
                            r_err_timeout <= 1'b0;
                            r_neuron_cnt  <= '0;
                            r_chunk_cnt   <= '0;
                        end else begin
                            // Empty layer: report completion without running.
                            r_layer_done <= 1'b1;
                        end
                    end
                end
                S_FEED: begin
                    if (bus.dma_valid) begin
                        r_chunk_cnt <= w_last_beat ? '0 : r_chunk_cnt + CHUNK_W'(1);
                    end
                end
                S_READ: begin
                    r_tcnt <= '0;
                end
                S_WAIT_DONE: begin
                    if (bus.mac_done) begin
                        r_res_data  <= bus.mac_result;
                        r_res_index <= r_neuron_cnt;
                    end else if (w_timeout_hit) begin
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                    end
                end
                S_EMIT: begin
                    if (bus.res_ready) begin
                        if (w_last_neuron) begin
                            r_layer_done <= 1'b1;
                        end else begin
                            r_neuron_cnt <= r_neuron_cnt + NEURON_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.layer_done  = r_layer_done;
    assign bus.err_timeout = r_err_timeout;
    assign bus.dma_ready   = w_dma_ready;
    assign bus.bias_idx    = r_neuron_cnt;
    assign bus.mac_en      = w_mac_en;
    assign bus.mac_clr     = w_mac_clr;
    assign bus.mac_read_en = w_mac_read_en;
    assign bus.mac_op_mode = r_op_mode;
    assign bus.res_valid   = w_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_index   = r_res_index;
endmodule

// File: tb/tb_mac_layer_sequencer.sv
module tb_mac_layer_sequencer;
    localparam int NW = 10;
    localparam int CW = 8;
    localparam int DW = 16;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mac_layer_sequencer_if #(.NEURON_W(NW), .CHUNK_W(CW), .DATA_W(DW)) bus ();

    mac_layer_sequencer #(
        .NEURON_W(NW), .CHUNK_W(CW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Stimulus record and expected layer-level outcome
    typedef struct {
        int nn; int cc; int op; int lat; int stall; int vpat; int vlen;
        int e_busy; int e_clr; int e_en; int e_rd; int e_res; int e_done; int e_err; int e_terr;
    } vec_t;

    typedef struct {
        int busy; int clr; int en; int rd; int res; int done; int err; int terr;
    } obs_t;

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.dma_valid   = 1'b0;
        bus.mac_done    = 1'b0;
        bus.mac_result  = '0;
        bus.res_ready   = 1'b0;
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_busy"},        int'(bus.busy), 0);
        chk({tag, "_layer_done"},  int'(bus.layer_done), 0);
        chk({tag, "_err_timeout"}, int'(bus.err_timeout), 0);
        chk({tag, "_dma_ready"},   int'(bus.dma_ready), 0);
        chk({tag, "_bias_idx"},    int'(bus.bias_idx), 0);
        chk({tag, "_mac_en"},      int'(bus.mac_en), 0);
        chk({tag, "_mac_clr"},     int'(bus.mac_clr), 0);
        chk({tag, "_mac_read_en"}, int'(bus.mac_read_en), 0);
        chk({tag, "_mac_op_mode"}, int'(bus.mac_op_mode), 0);
        chk({tag, "_res_valid"},   int'(bus.res_valid), 0);
        chk({tag, "_res_data"},    int'(bus.res_data), 0);
        chk({tag, "_res_index"},   int'(bus.res_index), 0);
    endtask

    // Runs one layer: drives start, plays the DMA source / datapath / result
    // sink, and checks the transaction-level rules of the layer every cycle.
    task automatic run_layer(input vec_t v, input bit rnd, output obs_t o);
        int n_exp = 0, beats = 0, cnt = 0, emit_cnt = 0, pidx = 0;
        int t_rd = -1, last_hs = -1, cyc = 0, exp_res;
        bit in_feed = 0, waiting = 0, started = 0, fin = 0, exp_rdy;
        bit prev_en = 0, prev_vld = 0, prev_rdy = 0, prev_busy = 0;
        logic [DW-1:0] prev_data = '0;
        logic [NW-1:0] prev_idx = '0;
        logic [DW-1:0] rq[$];
        logic [DW-1:0] exp_d;
        o = '{default: 0};
        o.terr = -1;
        exp_res = (v.nn > 0 && v.cc > 0) ? v.nn : 0;
        while (!fin && cyc < 1000) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (cyc == 0) begin
                bus.start           = 1'b1;
                bus.cfg_num_neurons = NW'(v.nn);
                bus.cfg_num_chunks  = CW'(v.cc);
                bus.cfg_op_mode     = v.op[0];
            end else if (rnd) begin
                bus.cfg_num_neurons = NW'($urandom);
                bus.cfg_num_chunks  = CW'($urandom);
                bus.cfg_op_mode     = 1'($urandom);
                if (prev_busy && !prev_vld) bus.start = ($urandom % 4 == 0);
            end
            if (in_feed && pidx < v.vlen) begin
                bus.dma_valid = v.vpat[pidx];
                pidx++;
            end else begin
                bus.dma_valid = rnd ? 1'($urandom) : 1'b1;
            end
            bus.mac_done   = 1'b0;
            bus.mac_result = DW'($urandom);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mac_done = 1'b1;
                    rq.push_back(bus.mac_result);
                end
            end else if (rnd && ($urandom % 4 == 0)) begin
                bus.mac_done = 1'b1;
            end
            bus.res_ready = rnd ? 1'($urandom) : (emit_cnt >= v.stall);
            #1;
            if (bus.busy) begin
                o.busy++;
                started = 1;
                chk("op_mode", int'(bus.mac_op_mode), v.op);
                chk("bias_idx", int'(bus.bias_idx), n_exp);
                chk("err_while_busy", int'(bus.err_timeout), 0);
            end
            chk("ctrl_mutex", int'(bus.mac_en) + int'(bus.mac_clr) + int'(bus.mac_read_en) <= 1 ? 1 : 0, 1);
            exp_rdy = in_feed && (beats < v.cc);
            chk("dma_ready", int'(bus.dma_ready), int'(exp_rdy));
            chk("mac_en", int'(bus.mac_en), int'(exp_rdy && bus.dma_valid));
            if (bus.mac_clr) begin
                o.clr++;
                chk("clr_order", int'(waiting || in_feed), 0);
                chk("clr_neuron_range", (n_exp < v.nn) ? 1 : 0, 1);
                in_feed = 1;
                beats   = 0;
            end
            if (bus.mac_en) begin
                o.en++;
                beats++;
            end
            if (bus.mac_read_en) begin
                o.rd++;
                chk("read_after_last_beat", int'(prev_en && beats == v.cc), 1);
                in_feed = 0;
                waiting = 1;
                cnt     = v.lat;
                t_rd    = cyc;
            end
            chk("res_valid_only_after_done", int'(!bus.res_valid || waiting), 1);
            if (prev_vld && !prev_rdy) begin
                chk("hold_valid", int'(bus.res_valid), 1);
                chk("hold_data", int'(bus.res_data), int'(prev_data));
                chk("hold_index", int'(bus.res_index), int'(prev_idx));
            end
            if (bus.res_valid && bus.res_ready) begin
                o.res++;
                chk("res_expected", rq.size() > 0 ? 1 : 0, 1);
                exp_d = (rq.size() > 0) ? rq.pop_front() : '0;
                chk("res_data", int'(bus.res_data), int'(exp_d));
                chk("res_index", int'(bus.res_index), n_exp);
                n_exp++;
                waiting = 0;
                last_hs = cyc;
            end
            if (bus.layer_done) begin
                o.done++;
                chk("layer_done_timing", cyc, (o.res > 0) ? last_hs + 1 : 1);
                chk("layer_done_results", n_exp, exp_res);
                chk("layer_done_busy", int'(bus.busy), 0);
            end
            if (bus.err_timeout && o.terr < 0 && t_rd >= 0) o.terr = cyc - t_rd;
            if (bus.layer_done || (started && !bus.busy)) fin = 1;
            emit_cnt  = (bus.res_valid && !bus.res_ready) ? emit_cnt + 1 : 0;
            prev_en   = bus.mac_en;
            prev_vld  = bus.res_valid;
            prev_rdy  = bus.res_ready;
            prev_data = bus.res_data;
            prev_idx  = bus.res_index;
            prev_busy = bus.busy;
            cyc++;
        end
        chk("cycle_budget", int'(fin), 1);
        o.err = int'(bus.err_timeout);
        idle_inputs();
    endtask

    vec_t tbl[10];
    vec_t v;
    obs_t o;

    initial begin
        // nn cc op lat stall vpat vlen | busy clr en rd res done err terr
        tbl[0] = '{2, 3,   1, 2,   0, 0,  0, 16,  2, 6,   2, 2, 1, 0, -1};
        tbl[1] = '{2, 4,   0, 1,   5, 0,  0, 26,  2, 8,   2, 2, 1, 0, -1};
        tbl[2] = '{3, 1,   0, 3,   1, 0,  0, 24,  3, 3,   3, 3, 1, 0, -1};
        tbl[3] = '{1, 4,   0, 1,   0, 89, 7, 11,  1, 4,   1, 1, 1, 0, -1};
        tbl[4] = '{1, 255, 1, 1,   0, 0,  0, 259, 1, 255, 1, 1, 1, 0, -1};
        tbl[5] = '{0, 3,   1, 1,   0, 0,  0, 0,   0, 0,   0, 0, 1, 0, -1};
        tbl[6] = '{2, 0,   0, 1,   0, 0,  0, 0,   0, 0,   0, 0, 1, 0, -1};
        tbl[7] = '{1, 1,   1, 255, 0, 0,  0, 259, 1, 1,   1, 1, 1, 0, -1};
        tbl[8] = '{1, 1,   0, 0,   0, 0,  0, 258, 1, 1,   1, 0, 0, 1, 256};
        tbl[9] = '{1, 2,   1, 1,   0, 0,  0, 6,   1, 2,   1, 1, 1, 0, -1};

        idle_inputs();
        bus.cfg_num_neurons = '0;
        bus.cfg_num_chunks  = '0;
        bus.cfg_op_mode     = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_layer(tbl[i], 1'b0, o);
            chk($sformatf("v%0d_busy_cycles", i), o.busy, tbl[i].e_busy);
            chk($sformatf("v%0d_clr", i),         o.clr,  tbl[i].e_clr);
            chk($sformatf("v%0d_en", i),          o.en,   tbl[i].e_en);
            chk($sformatf("v%0d_read", i),        o.rd,   tbl[i].e_rd);
            chk($sformatf("v%0d_results", i),     o.res,  tbl[i].e_res);
            chk($sformatf("v%0d_layer_done", i),  o.done, tbl[i].e_done);
            chk($sformatf("v%0d_err", i),         o.err,  tbl[i].e_err);
            chk($sformatf("v%0d_err_latency", i), o.terr, tbl[i].e_terr);
        end

        // Asynchronous reset while feeding a layer
        @(posedge clk);
        #1;
        bus.start           = 1'b1;
        bus.cfg_num_neurons = NW'(2);
        bus.cfg_num_chunks  = CW'(4);
        bus.cfg_op_mode     = 1'b1;
        bus.dma_valid       = 1'b1;
        bus.res_ready       = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_reset_mac_en", int'(bus.mac_en), 1);
        chk("pre_reset_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        v = tbl[9];
        run_layer(v, 1'b0, o);
        chk("post_reset_results", o.res, 1);
        chk("post_reset_en", o.en, 2);
        chk("post_reset_done", o.done, 1);

        // Randomized layers against the transaction-level model
        for (int i = 0; i < 25; i++) begin
            v = '{default: 0};
            v.nn  = $urandom_range(1, 4);
            v.cc  = $urandom_range(1, 6);
            v.op  = $urandom_range(0, 1);
            v.lat = $urandom_range(1, 6);
            run_layer(v, 1'b1, o);
            chk($sformatf("rnd%0d_clr", i),  o.clr,  v.nn);
            chk($sformatf("rnd%0d_en", i),   o.en,   v.nn * v.cc);
            chk($sformatf("rnd%0d_read", i), o.rd,   v.nn);
            chk($sformatf("rnd%0d_res", i),  o.res,  v.nn);
            chk($sformatf("rnd%0d_done", i), o.done, 1);
            chk($sformatf("rnd%0d_err", i),  o.err,  0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
